// File: rtl/rand_game_pkg.sv
// Shared types and helpers for the random-sequence game blocks.
// Holds the FSM state type, nibble width and index-width helper.
package rand_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHOW,
        GUESS,
        DONE
    } state_t;

    localparam int NIBBLE_W = 4;

    // Index width for a buffer of n entries; never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_show_timer.sv
// Display dwell timer: counts 0..SHOW_CYCLES-1 while en is high.
// Ports: clk, rst (sync, active high), clr (restart), en, tick (terminal count).
module seq_show_timer #(
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(SHOW_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rand_sequence_checker.sv
// Captures a nibble sequence, replays it for display, then checks guesses.
// Ports: clk, rst, start, rand_in, guess_valid, guess -> busy, show_valid,
// show_value, show_idx, round_done, round_pass, err_idx (all registered).
// Option: define SEQ_NO_REPEAT_EN to drop samples equal to the previous entry.
module rand_sequence_checker
    import rand_game_pkg::*;
#(
    parameter int SEQ_LEN     = 8,
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NIBBLE_W-1:0]        rand_in,
    input  logic                       guess_valid,
    input  logic [NIBBLE_W-1:0]        guess,
    output logic                       busy,
    output logic                       show_valid,
    output logic [NIBBLE_W-1:0]        show_value,
    output logic [idx_w(SEQ_LEN)-1:0]  show_idx,
    output logic                       round_done,
    output logic                       round_pass,
    output logic [idx_w(SEQ_LEN)-1:0]  err_idx
);

    localparam int IDX_W = idx_w(SEQ_LEN);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    state_t              state;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic [NIBBLE_W-1:0] mem [SEQ_LEN];

    logic skip;
    logic cap_we;
    logic cap_last;
    logic show_tick;
    logic match;

    always_comb begin
        skip = 1'b0;
`ifdef SEQ_NO_REPEAT_EN
        skip = (wr_idx != '0) && (rand_in == mem[wr_idx - ONE]);
`endif
    end

    assign cap_we   = (state == CAPTURE) && !skip;
    assign cap_last = cap_we && (wr_idx == LAST);
    assign match    = (guess == mem[rd_idx]);

    // Buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (cap_we) begin
            mem[wr_idx] <= rand_in;
        end
    end

    // Timer restarts on the capture->show transition.
    seq_show_timer #(
        .SHOW_CYCLES(SHOW_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (cap_last),
        .en  (state == SHOW),
        .tick(show_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_idx     <= '0;
            rd_idx     <= '0;
            busy       <= 1'b0;
            show_valid <= 1'b0;
            show_value <= '0;
            show_idx   <= '0;
            round_done <= 1'b0;
            round_pass <= 1'b0;
            err_idx    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CAPTURE;
                        wr_idx     <= '0;
                        round_pass <= 1'b0;
                        err_idx    <= '0;
                        busy       <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (cap_last) begin
                        // mem[0] was written on an earlier cycle.
                        state      <= SHOW;
                        rd_idx     <= '0;
                        show_valid <= 1'b1;
                        show_value <= mem[0];
                        show_idx   <= '0;
                    end else if (cap_we) begin
                        wr_idx <= wr_idx + ONE;
                    end
                end
                SHOW: begin
                    if (show_tick) begin
                        if (rd_idx == LAST) begin
                            state      <= GUESS;
                            rd_idx     <= '0;
                            show_valid <= 1'b0;
                            show_value <= '0;
                            show_idx   <= '0;
                        end else begin
                            rd_idx     <= rd_idx + ONE;
                            show_idx   <= rd_idx + ONE;
                            show_value <= mem[rd_idx + ONE];
                        end
                    end
                end
                GUESS: begin
                    if (guess_valid) begin
                        if (!match) begin
                            state      <= DONE;
                            round_done <= 1'b1;
                            round_pass <= 1'b0;
                            err_idx    <= rd_idx;
                        end else if (rd_idx == LAST) begin
                            state      <= DONE;
                            round_done <= 1'b1;
                            round_pass <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + ONE;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    round_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_sequence_checker.sv
// Directed self-checking bench for rand_sequence_checker.
// Uses SEQ_LEN=4, SHOW_CYCLES=3; honours SEQ_NO_REPEAT_EN if defined.
module tb_rand_sequence_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] rand_in;
    logic       guess_valid;
    logic [3:0] guess;
    logic       busy;
    logic       show_valid;
    logic [3:0] show_value;
    logic [1:0] show_idx;
    logic       round_done;
    logic       round_pass;
    logic [1:0] err_idx;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rand_sequence_checker #(
        .SEQ_LEN    (4),
        .SHOW_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rand_in    (rand_in),
        .guess_valid(guess_valid),
        .guess      (guess),
        .busy       (busy),
        .show_valid (show_valid),
        .show_value (show_value),
        .show_idx   (show_idx),
        .round_done (round_done),
        .round_pass (round_pass),
        .err_idx    (err_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_guess(input logic [3:0] g);
        guess_valid = 1'b1;
        guess       = g;
        step();
        guess_valid = 1'b0;
    endtask

    // Start a round and feed four nibbles; leaves DUT at first SHOW cycle.
    task automatic start_and_capture(input logic [15:0] vals);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("pass_cleared", int'(round_pass), 0);
        for (int i = 0; i < 4; i++) begin
            rand_in = vals[15-4*i -: 4];
            step();
        end
    endtask

    // Walk through the whole replay checking every displayed cycle.
    task automatic check_show(input logic [15:0] vals);
        for (int e = 0; e < 4; e++) begin
            for (int c = 0; c < 3; c++) begin
                chk("show_valid", int'(show_valid), 1);
                chk("show_value", int'(show_value), int'(vals[15-4*e -: 4]));
                chk("show_idx", int'(show_idx), e);
                step();
            end
        end
        chk("show_end_valid", int'(show_valid), 0);
        chk("show_end_value", int'(show_value), 0);
        chk("show_end_busy", int'(busy), 1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        rand_in     = 4'd0;
        guess_valid = 1'b0;
        guess       = 4'd0;

        // 1: reset
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_show_valid", int'(show_valid), 0);
        chk("rst_show_value", int'(show_value), 0);
        chk("rst_show_idx", int'(show_idx), 0);
        chk("rst_round_done", int'(round_done), 0);
        chk("rst_round_pass", int'(round_pass), 0);
        chk("rst_err_idx", int'(err_idx), 0);
        rst = 1'b0;
        step();

        // 2 + 3: full pass round
        start_and_capture(16'h5927);
        check_show(16'h5927);
        do_guess(4'd5);
        do_guess(4'd9);
        do_guess(4'd2);
        chk("pass_pre_done", int'(round_done), 0);
        do_guess(4'd7);
        chk("pass_done", int'(round_done), 1);
        chk("pass_flag", int'(round_pass), 1);
        chk("pass_busy_done", int'(busy), 1);
        step();
        chk("pass_done_pulse", int'(round_done), 0);
        chk("pass_busy_idle", int'(busy), 0);
        chk("pass_flag_held", int'(round_pass), 1);
        chk("pass_err_idx", int'(err_idx), 0);

        // 4: failing round, wrong at index 2
        start_and_capture(16'h5927);
        check_show(16'h5927);
        do_guess(4'd5);
        do_guess(4'd9);
        do_guess(4'd3);
        chk("fail_done", int'(round_done), 1);
        chk("fail_flag", int'(round_pass), 0);
        chk("fail_err_idx", int'(err_idx), 2);
        step();
        chk("fail_done_pulse", int'(round_done), 0);
        chk("fail_busy_idle", int'(busy), 0);
        do_guess(4'd7);
        chk("fail_ignored_done", int'(round_done), 0);
        chk("fail_ignored_busy", int'(busy), 0);
        chk("fail_err_held", int'(err_idx), 2);

        // 5: start in SHOW ignored, rst in SHOW, guess in IDLE
        start_and_capture(16'h1234);
        chk("s5_show_val0", int'(show_value), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s5_start_ign_val", int'(show_value), 1);
        chk("s5_start_ign_idx", int'(show_idx), 0);
        chk("s5_start_ign_busy", int'(busy), 1);
        step();
        step();
        chk("s5_next_entry", int'(show_value), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s5_rst_valid", int'(show_valid), 0);
        chk("s5_rst_busy", int'(busy), 0);
        chk("s5_rst_err", int'(err_idx), 0);
        do_guess(4'd1);
        chk("s5_idle_guess_busy", int'(busy), 0);
        chk("s5_idle_guess_done", int'(round_done), 0);

        // 6: repeated samples
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef SEQ_NO_REPEAT_EN
        begin
            logic [23:0] seq6;
            seq6 = 24'h559927;
            for (int i = 0; i < 6; i++) begin
                chk("s6_capturing", int'(show_valid), 0);
                rand_in = seq6[23-4*i -: 4];
                step();
            end
        end
        check_show(16'h5927);
`else
        begin
            logic [23:0] seq6;
            seq6 = 24'h559927;
            for (int i = 0; i < 4; i++) begin
                chk("s6_capturing", int'(show_valid), 0);
                rand_in = seq6[23-4*i -: 4];
                step();
            end
        end
        check_show(16'h5599);
`endif
        do_guess(4'd0);
        chk("s6_err_idx", int'(err_idx), 0);
        chk("s6_done", int'(round_done), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
